pipeline_hazard_controller: RTL

Central sequencing controller for the 5-stage ARM pipeline (IF, ID, EXE, MEM, WB). It generates the freeze, flush and bubble controls for every stage register from three sources:
- register-dependency hazards;
- taken branches resolved in EXE;
- multi-cycle data-memory accesses with a fixed number of wait states.

It replaces the constant-zero freeze/flush ties at the core top level. It sits beside the pipeline and drives only control inputs; it carries no data.

---
 rtl/pipeline_ctrl_pkg.sv | 29 ++
 rtl/mem_wait_fsm.sv | 86 ++++++++
 rtl/pipeline_hazard_controller.sv | 118 +++++++++++
 3 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
// Holds the register-index width, the default memory timing, the memory
// FSM state encoding and the source-operand match helper used by the
// hazard detector.
package pipeline_ctrl_pkg;

  localparam int REG_IDX_W        = 4;
  localparam int DEFAULT_MEM_WAIT = 3;
  localparam int DEFAULT_CNT_W    = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RELEASE = 2'd2
  } mem_state_e;

  // True when the ID instruction actually reads register 'dest' through
  // either of its source operands.
  function automatic logic srcMatch(
    input logic                 usesSrc1,
    input logic [REG_IDX_W-1:0] src1,
    input logic                 twoSrc,
    input logic [REG_IDX_W-1:0] src2,
    input logic [REG_IDX_W-1:0] dest
  );
    return (usesSrc1 && (src1 == dest)) || (twoSrc && (src2 == dest));
  endfunction

endpackage

// File: rtl/mem_wait_fsm.sv
// Memory wait-state sequencer.
// Stalls the pipeline for exactly MEM_WAIT cycles per data-memory access,
// then spends one RELEASE cycle unstalled so the access can retire before
// another access is recognised in IDLE.
// Ports:
//   clk, rst            core clock, synchronous active-low reset
//   mem_r_en, mem_w_en  MEM-stage instruction reads / writes data memory
//   mstall              pipeline must hold this cycle
//   mem_busy            FSM is in (or entering) a stall sequence
module mem_wait_fsm
  import pipeline_ctrl_pkg::*;
#(
  parameter int MEM_WAIT = DEFAULT_MEM_WAIT,
  parameter int CNT_W    = DEFAULT_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic mem_r_en,
  input  logic mem_w_en,
  output logic mstall,
  output logic mem_busy
);

  localparam logic             HAS_WAIT = (MEM_WAIT > 0);
  localparam logic [CNT_W-1:0] LOAD_CNT = (MEM_WAIT > 0) ? CNT_W'(MEM_WAIT - 1) : '0;
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

  mem_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             acc;

  assign acc = mem_r_en | mem_w_en;

  // State and wait counter registers; reset abandons any access in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and stall decode. The IDLE cycle that detects the access is
  // itself the first stall cycle, so WAIT covers the remaining MEM_WAIT-1.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mstall   = 1'b0;
    mem_busy = 1'b0;
    case (state_q)
      IDLE: begin
        if (acc && HAS_WAIT) begin
          mstall   = 1'b1;
          mem_busy = 1'b1;
          cnt_d    = LOAD_CNT;
          state_d  = (LOAD_CNT == '0) ? RELEASE : WAIT;
        end
      end
      WAIT: begin
        mstall   = 1'b1;
        mem_busy = 1'b1;
        cnt_d    = cnt_q - ONE_CNT;
        // A zero count can only come from corruption; leave rather than wrap.
        if (cnt_q <= ONE_CNT) begin
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        mem_busy = 1'b1;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    // Outputs are silenced for the whole time reset is held.
    if (!rst) begin
      mstall   = 1'b0;
      mem_busy = 1'b0;
    end
  end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Pipeline sequencing controller for the 5-stage core.
// Combines register-dependency hazards, taken branches from EXE and
// multi-cycle memory stalls into per-stage freeze/flush/bubble controls.
// Priority: memory stall > branch flush > data hazard.
// Ports:
//   clk, rst                   core clock, synchronous active-low reset
//   id_src1/id_src2            source register indices of the ID instruction
//   id_uses_src1/id_two_src    which ID sources are really read
//   exe_dest/exe_wb_en         EXE destination and writeback enable
//   exe_mem_r_en               EXE instruction is a load
//   mem_dest/mem_wb_en         MEM destination and writeback enable
//   mem_r_en/mem_w_en          MEM instruction accesses data memory
//   exe_branch_taken           branch resolved taken in EXE
//   pc_freeze .. exe_reg_freeze  stage register hold/clear controls
//   mem_reg_bubble             MEM/WB loads a bubble
//   mem_busy                   memory sequencer active (debug/perf)
module pipeline_hazard_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int MEM_WAIT = DEFAULT_MEM_WAIT,
  parameter int FWD_EN   = 0,
  parameter int CNT_W    = DEFAULT_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_IDX_W-1:0] id_src1,
  input  logic [REG_IDX_W-1:0] id_src2,
  input  logic                 id_two_src,
  input  logic                 id_uses_src1,
  input  logic [REG_IDX_W-1:0] exe_dest,
  input  logic                 exe_wb_en,
  input  logic                 exe_mem_r_en,
  input  logic [REG_IDX_W-1:0] mem_dest,
  input  logic                 mem_wb_en,
  input  logic                 mem_r_en,
  input  logic                 mem_w_en,
  input  logic                 exe_branch_taken,
  output logic                 pc_freeze,
  output logic                 if_reg_freeze,
  output logic                 if_reg_flush,
  output logic                 id_reg_freeze,
  output logic                 id_reg_flush,
  output logic                 exe_reg_freeze,
  output logic                 mem_reg_bubble,
  output logic                 mem_busy
);

  logic mstall;
  logic exeMatch, memMatch, hz, fl;
  logic br_pending_q, br_pending_d;

  mem_wait_fsm #(
    .MEM_WAIT (MEM_WAIT),
    .CNT_W    (CNT_W)
  ) u_mem_wait_fsm (
    .clk      (clk),
    .rst      (rst),
    .mem_r_en (mem_r_en),
    .mem_w_en (mem_w_en),
    .mstall   (mstall),
    .mem_busy (mem_busy)
  );

  // With forwarding, only a load in EXE cannot be bypassed in time; without
  // it, any pending writeback in EXE or MEM forces ID to wait.
  always_comb begin
    exeMatch = srcMatch(id_uses_src1, id_src1, id_two_src, id_src2, exe_dest);
    memMatch = srcMatch(id_uses_src1, id_src1, id_two_src, id_src2, mem_dest);
    if (FWD_EN != 0) begin
      hz = exe_mem_r_en && exe_wb_en && exeMatch;
    end else begin
      hz = (exe_wb_en && exeMatch) || (mem_wb_en && memMatch);
    end
  end

  assign fl = exe_branch_taken | br_pending_q;

  // A branch seen while memory stalls the pipe is remembered until the
  // first unstalled cycle, where its flush is issued.
  always_ff @(posedge clk) begin
    if (!rst) begin
      br_pending_q <= 1'b0;
    end else begin
      br_pending_q <= br_pending_d;
    end
  end

  // Priority mux. A branch beats a hazard because the hazarding ID
  // instruction is on the wrong path and is about to be discarded anyway.
  always_comb begin
    pc_freeze      = 1'b0;
    if_reg_freeze  = 1'b0;
    if_reg_flush   = 1'b0;
    id_reg_freeze  = 1'b0;
    id_reg_flush   = 1'b0;
    exe_reg_freeze = 1'b0;
    mem_reg_bubble = 1'b0;
    br_pending_d   = 1'b0;
    if (rst) begin
      if (mstall) begin
        pc_freeze      = 1'b1;
        if_reg_freeze  = 1'b1;
        id_reg_freeze  = 1'b1;
        exe_reg_freeze = 1'b1;
        mem_reg_bubble = 1'b1;
        br_pending_d   = br_pending_q | exe_branch_taken;
      end else if (fl) begin
        if_reg_flush = 1'b1;
        id_reg_flush = 1'b1;
      end else if (hz) begin
        pc_freeze     = 1'b1;
        if_reg_freeze = 1'b1;
        id_reg_flush  = 1'b1;
      end
    end
  end

endmodule
